ram_arb: RTL and testbench

RAM_ARB -- requirements
Module: ram_arb

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram1.sv | 25 ++
 rtl/rr_pick2.sv | 29 ++
 rtl/ram_arb.sv | 169 ++++++++++++++++
 tb/tb_ram_arb.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM arbiter: default widths and controller state encoding.
package ram_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_BURST_DEF  = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    // One-hot grant vector for a two-way selection index.
    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram1.sv
// Single-port RAM with registered read data (read-before-write on the same port).
module ram1 #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    input  logic          we
);

    logic [DW-1:0] mem_r [2**AW];

    // Registered read of the presented address and optional write.
    always_ff @(posedge clk) begin
        o_data <= mem_r[addr];
        if (we) begin
            mem_r[addr] <= i_data;
        end else begin
            mem_r[addr] <= mem_r[addr];
        end
    end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker with a lock override that keeps the previous winner.
module rr_pick2
    import ram_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       last_winner,
    input  logic       burst_full,
    output logic [1:0] grant
);

    // Choose the single requester, or under contention the locked holder / round-robin turn.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (lock[last_winner] && !burst_full) begin
                    grant = onehot2(last_winner);
                end else begin
                    grant = onehot2(~last_winner);
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arb.sv
// Two-requester arbiter in front of a single-port RAM; clears the RAM after reset.
module ram_arb
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  lock0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  lock1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = CNT_W'(0);

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] init_cnt_r;
    logic                  last_winner_r;
    logic [CNT_W-1:0]      burst_cnt_r;
    logic                  prev_valid_r;
    logic [1:0]            rvalid_r;

    logic [1:0]            req_s;
    logic [1:0]            lock_s;
    logic [1:0]            we_s;
    logic [1:0]            lock_eff_s;
    logic [1:0]            pick_s;
    logic [1:0]            gnt_s;
    logic                  win_s;
    logic                  any_gnt_s;
    logic                  burst_full_s;
    logic [CNT_W-1:0]      burst_nxt_s;

    assign req_s        = {req1, req0};
    assign lock_s       = {lock1, lock0};
    assign we_s         = {we1, we0};
    // A lock only holds the grant if somebody actually held it last cycle.
    assign lock_eff_s   = lock_s & {2{prev_valid_r}};
    assign burst_full_s = (burst_cnt_r == BURST_MAX);
    assign win_s        = gnt_s[1];
    assign any_gnt_s    = |gnt_s;

    rr_pick2 u_pick (
        .req         (req_s),
        .lock        (lock_eff_s),
        .last_winner (last_winner_r),
        .burst_full  (burst_full_s),
        .grant       (pick_s)
    );

    // Grants exist only while arbitrating and out of reset.
    always_comb begin
        gnt_s = 2'b00;
        if (rst_n && (state_r == ST_ARB)) begin
            gnt_s = pick_s;
        end else begin
            gnt_s = 2'b00;
        end
    end

    // RAM port: clear sweep during INIT, otherwise the winner's access.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = {ADDR_WIDTH{1'b0}};
        ram_wdata = {DATA_WIDTH{1'b0}};
        if (!rst_n) begin
            ram_we = 1'b0;
        end else if (state_r == ST_INIT) begin
            ram_we   = 1'b1;
            ram_addr = init_cnt_r;
        end else if (gnt_s[1]) begin
            ram_we    = we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end else if (gnt_s[0]) begin
            ram_we    = we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else begin
            ram_we = 1'b0;
        end
    end

    // Burst length including the current grant; restarts at 1 for a fresh or renewed locked streak.
    always_comb begin
        burst_nxt_s = CNT_ZERO;
        if (!any_gnt_s) begin
            burst_nxt_s = CNT_ZERO;
        end else if (!lock_s[win_s]) begin
            burst_nxt_s = CNT_ZERO;
        end else if (prev_valid_r && (win_s == last_winner_r) &&
                     (burst_cnt_r != CNT_ZERO) && !burst_full_s) begin
            burst_nxt_s = burst_cnt_r + CNT_ONE;
        end else begin
            burst_nxt_s = CNT_ONE;
        end
    end

    // Controller state, clear sweep counter, arbitration history and read-valid pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_INIT;
            init_cnt_r    <= {ADDR_WIDTH{1'b0}};
            last_winner_r <= 1'b1;
            burst_cnt_r   <= CNT_ZERO;
            prev_valid_r  <= 1'b0;
            rvalid_r      <= 2'b00;
        end else begin
            rvalid_r <= gnt_s & ~we_s;
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    if (init_cnt_r == LAST_ADDR) begin
                        state_r <= ST_ARB;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_ARB: begin
                    state_r      <= ST_ARB;
                    prev_valid_r <= any_gnt_s;
                    burst_cnt_r  <= burst_nxt_s;
                    if (any_gnt_s) begin
                        last_winner_r <= win_s;
                    end else begin
                        last_winner_r <= last_winner_r;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    assign gnt0      = gnt_s[0];
    assign gnt1      = gnt_s[1];
    assign rvalid0   = rvalid_r[0];
    assign rvalid1   = rvalid_r[1];
    assign rdata0    = rvalid_r[0] ? ram_rdata : {DATA_WIDTH{1'b0}};
    assign rdata1    = rvalid_r[1] ? ram_rdata : {DATA_WIDTH{1'b0}};
    assign init_done = (state_r == ST_ARB);

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb + ram1: directed stimulus, behavioural model checked every cycle.
module tb_ram_arb;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, lock0, we0, req1, lock1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       init_done;

    int total = 0;
    int bad   = 0;
    int n_init_we = 0;
    logic [31:0] tr0 = 32'd0;

    // model state
    bit         m_known = 1'b0;
    bit         m_init;
    int         m_iaddr, m_last, m_prev, m_run, exp_w;
    bit   [1:0] m_rv;
    logic [7:0] m_rd [2];
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    ram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .init_done(init_done)
    );

    ram1 #(.AW(4), .DW(8)) u_ram (
        .clk(clk), .addr(ram_addr), .i_data(ram_wdata), .o_data(ram_rdata), .we(ram_we)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_lock(input int i); return (i == 1) ? lock1 : lock0; endfunction
    function automatic bit f_we(input int i);   return (i == 1) ? we1 : we0;     endfunction
    function automatic logic [3:0] f_addr(input int i);  return (i == 1) ? addr1 : addr0;   endfunction
    function automatic logic [7:0] f_wdata(input int i); return (i == 1) ? wdata1 : wdata0; endfunction

    // Expected winner: lone requester; else locked previous winner unless its streak just hit a multiple of MB; else the other one.
    function automatic int model_pick();
        if (req0 && !req1) return 0;
        if (req1 && !req0) return 1;
        if (!req0 && !req1) return -1;
        if (m_prev >= 0 && f_lock(m_prev) && !(m_run > 0 && (m_run % MB) == 0)) return m_prev;
        return 1 - m_last;
    endfunction

    // Compare DUT outputs with the model away from the rising edge.
    always @(negedge clk) begin
        if (m_known) begin
            if (!rst_n) begin
                exp_w = -1;
                n_init_we = 0;
                chk("rst_gnt0", gnt0, 0);
                chk("rst_gnt1", gnt1, 0);
                chk("rst_ram_we", ram_we, 0);
            end else if (m_init) begin
                exp_w = -1;
                if (ram_we === 1'b1) n_init_we++;
                chk("init_gnt0", gnt0, 0);
                chk("init_gnt1", gnt1, 0);
                chk("init_done_lo", init_done, 0);
                chk("init_we", ram_we, 1);
                chk("init_addr", ram_addr, m_iaddr);
                chk("init_wdata", ram_wdata, 0);
                chk("init_rvalid0", rvalid0, 0);
                chk("init_rvalid1", rvalid1, 0);
            end else begin
                exp_w = model_pick();
                chk("init_done_hi", init_done, 1);
                chk("gnt0", gnt0, (exp_w == 0) ? 1 : 0);
                chk("gnt1", gnt1, (exp_w == 1) ? 1 : 0);
                if (exp_w >= 0) begin
                    chk("ram_we", ram_we, f_we(exp_w));
                    chk("ram_addr", ram_addr, f_addr(exp_w));
                    if (f_we(exp_w)) chk("ram_wdata", ram_wdata, f_wdata(exp_w));
                end else begin
                    chk("ram_we_idle", ram_we, 0);
                end
                chk("rvalid0", rvalid0, m_rv[0]);
                chk("rvalid1", rvalid1, m_rv[1]);
                chk("rdata0", rdata0, m_rv[0] ? m_rd[0] : 8'h00);
                chk("rdata1", rdata1, m_rv[1] ? m_rd[1] : 8'h00);
            end
        end
    end

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_known = 1'b1; m_init = 1'b1; m_iaddr = 0;
            m_last = 1; m_prev = -1; m_run = 0; m_rv = 2'b00;
        end else if (m_known) begin
            if (m_init) begin
                mem[m_iaddr] = 8'h00;
                if (m_iaddr == 15) m_init = 1'b0;
                m_iaddr++;
            end else begin
                m_rv = 2'b00;
                if (exp_w >= 0) begin
                    if (f_lock(exp_w)) m_run = (exp_w == m_prev && m_run > 0) ? m_run + 1 : 1;
                    else m_run = 0;
                    m_last = exp_w;
                    m_prev = exp_w;
                    if (f_we(exp_w)) mem[f_addr(exp_w)] = f_wdata(exp_w);
                    else begin
                        m_rv[exp_w] = 1'b1;
                        m_rd[exp_w] = mem[f_addr(exp_w)];
                    end
                end else begin
                    m_run = 0;
                    m_prev = -1;
                end
            end
        end
    end

    // One cycle; gnt0 is logged mid-cycle once the inputs have settled.
    task automatic step();
        #2;
        tr0 = {tr0[30:0], gnt0};
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 40 && init_done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("init_timeout", init_done, 1);
        chk("init_we_cycles", n_init_we, 16);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; lock0 = 1'b0; we0 = 1'b0; addr0 = 4'd0; wdata0 = 8'h00;
        req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0; addr1 = 4'd0; wdata1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_init_done", init_done, 0);
        chk("reset_rvalid0", rvalid0, 0);
        chk("reset_gnt0", gnt0, 0);
        chk("reset_ram_we", ram_we, 0);
        rst_n = 1'b1;
        wait_init();

        // read back every address after the clear sweep
        for (int a = 0; a < 16; a++) begin
            req0 = 1'b1; we0 = 1'b0; addr0 = 4'(a);
            step();
        end

        // write 0x5A to 3, then read it back
        we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'h5A;
        step();
        we0 = 1'b0;
        step();
        req0 = 1'b0;
        chk("raw_rvalid0", rvalid0, 1);
        chk("raw_rdata0", rdata0, 8'h5A);
        chk("raw_rdata1", rdata1, 8'h00);

        // contention without lock: requester 1 is due first, then strict alternation
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd7;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; wdata1 = 8'h33;
        tr0 = 32'd0;
        repeat (8) step();
        chk("alternate", tr0[7:0], 8'b01010101);
        chk("alt_rdata0", rdata0, 8'h33);

        // lock0 held: four grants to 0, one to 1, repeat
        lock0 = 1'b1;
        tr0 = 32'd0;
        repeat (10) step();
        chk("lock_burst", tr0[9:0], 10'b1111011110);
        req1 = 1'b0;
        tr0 = 32'd0;
        repeat (6) step();
        chk("lock_alone", tr0[5:0], 6'b111111);

        // reset pulse during a locked burst with a read outstanding
        req1 = 1'b1; addr0 = 4'd3;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rst_rvalid_drop", rvalid0, 0);
        chk("rst_init_done", init_done, 0);
        rst_n = 1'b1;
        wait_init();
        #1;
        chk("resume_favour0", gnt0, 1);
        chk("resume_gnt1", gnt1, 0);
        step();
        chk("resume_rvalid0", rvalid0, 1);
        chk("resume_cleared", rdata0, 8'h00);
        lock0 = 1'b0;
        step();
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
